// File: rtl/mmio_sig_monitor.sv
// mmio_sig_monitor
// ----------------
// Watches the tiny-SoC MMIO write port and turns the signature writes into
// run results:
//   * stop / trap writes drive the end-of-run FSM (RUN -> DRAIN -> DONE),
//     with a fixed drain of STOP_DELAY cycles before done is raised;
//   * a cycle counter ends the run directly when simlen_i is reached;
//   * integer / FP register-dump writes are queued as {kind, index, data}
//     records in a small FIFO and streamed out over valid/ready.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   mmio_req_i/we_i        MMIO request qualifiers (only writes are decoded)
//   mmio_addr_i            31-bit MMIO address
//   mmio_wdata_i           64-bit write data (captured in full)
//   mmio_strb_i            byte strobes, not used
//   simlen_i               cycle limit, 0 disables it
//   stop_on_trap_i         1: a trap write ends the run, 0: it is only counted
//   dump_valid_o/ready_i   record stream handshake
//   dump_is_fp_o           record kind, 0 = x-reg, 1 = f-reg
//   dump_idx_o/data_o      register index and value of the head record
//   overflow_o             sticky: a record was dropped because the FIFO was full
//   trap_count_o           trap writes seen while running, saturating
//   done_o/done_reason_o   sticky run-finished flag; reason 1 stop, 2 trap, 3 simlen

module mmio_sig_monitor #(
  parameter logic [30:0] ADDR_STOP_SIG  = 31'h60000000,
  parameter logic [30:0] ADDR_TRAP_SIG  = 31'h60000008,
  parameter logic [30:0] ADDR_REG_DUMP  = 31'h60000010,
  parameter logic [30:0] ADDR_FREG_DUMP = 31'h60000018,
  parameter int          STOP_DELAY     = 500,
  parameter int          FIFO_DEPTH     = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mmio_req_i,
  input  logic        mmio_we_i,
  input  logic [30:0] mmio_addr_i,
  input  logic [63:0] mmio_wdata_i,
  input  logic [7:0]  mmio_strb_i,
  input  logic [31:0] simlen_i,
  input  logic        stop_on_trap_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic        dump_is_fp_o,
  output logic [4:0]  dump_idx_o,
  output logic [63:0] dump_data_o,
  output logic        overflow_o,
  output logic [15:0] trap_count_o,
  output logic        done_o,
  output logic [1:0]  done_reason_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  // +2 keeps the width at least one bit even for STOP_DELAY = 0.
  localparam int CW = $clog2(STOP_DELAY + 2);
  localparam int RW = 1 + 5 + 64;
  localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DELAY_C = CW'(STOP_DELAY);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [31:0]   cycle_reg;
  logic [CW-1:0] countdown_reg;
  logic [1:0]    reason_reg;
  logic [15:0]   trap_count_reg;

  // Strobes carry no information for this monitor; full words are captured.
  logic unused_strb;
  assign unused_strb = ^mmio_strb_i;

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  logic wr_hit, hit_stop, hit_trap, hit_reg, hit_freg, in_run, simlen_hit;

  assign wr_hit   = mmio_req_i & mmio_we_i;
  assign hit_stop = wr_hit & (mmio_addr_i == ADDR_STOP_SIG);
  assign hit_trap = wr_hit & (mmio_addr_i == ADDR_TRAP_SIG);
  assign hit_reg  = wr_hit & (mmio_addr_i == ADDR_REG_DUMP);
  assign hit_freg = wr_hit & (mmio_addr_i == ADDR_FREG_DUMP);
  assign in_run   = (state_reg == ST_RUN);
  // The counter equals the index of the current edge, so the limit is hit
  // on edge simlen-1 and done is visible right after it.
  assign simlen_hit = (simlen_i != 32'd0) && (cycle_reg == simlen_i - 32'd1);

  // ------------------------------------------------------------------
  // End-of-run FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // End-of-run FSM: next state. Stop/trap take priority over simlen.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (hit_stop || (hit_trap && stop_on_trap_i)) begin
          state_next = ST_DRAIN;
        end else if (simlen_hit) begin
          state_next = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (countdown_reg == '0) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_DONE;
    endcase
  end

  // End-of-run FSM: outputs. The reason only becomes visible once done.
  always_comb begin
    done_o        = (state_reg == ST_DONE);
    done_reason_o = (state_reg == ST_DONE) ? reason_reg : 2'd0;
    trap_count_o  = trap_count_reg;
  end

  // Datapath that travels with the FSM: cycle counter, drain countdown,
  // latched reason and the trap counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_reg      <= '0;
      countdown_reg  <= '0;
      reason_reg     <= 2'd0;
      trap_count_reg <= 16'd0;
    end else begin
      if (state_reg != ST_DONE) begin
        cycle_reg <= cycle_reg + 32'd1;
      end
      if (in_run) begin
        if (hit_stop) begin
          reason_reg    <= 2'd1;
          countdown_reg <= DELAY_C;
        end else if (hit_trap && stop_on_trap_i) begin
          reason_reg    <= 2'd2;
          countdown_reg <= DELAY_C;
        end else if (simlen_hit) begin
          reason_reg    <= 2'd3;
        end
        if (hit_trap && (trap_count_reg != 16'hFFFF)) begin
          trap_count_reg <= trap_count_reg + 16'd1;
        end
      end else if ((state_reg == ST_DRAIN) && (countdown_reg != '0)) begin
        countdown_reg <= countdown_reg - 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Dump-record FIFO
  // ------------------------------------------------------------------
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [PW:0]   count_reg, count_after_pop, count_next;
  logic [4:0]    x_idx_reg, f_idx_reg;
  logic          overflow_reg, dump_valid_reg;
  logic [RW-1:0] dump_rec_reg, push_rec, head_next;
  logic          dump_hit, pop, push_ok;

  assign dump_hit = in_run & (hit_reg | hit_freg);
  assign push_rec = {hit_freg, (hit_freg ? f_idx_reg : x_idx_reg), mmio_wdata_i};
  assign pop      = dump_valid_reg & dump_ready_i;

  // A pop frees its slot on the same edge, so a full FIFO that is being
  // drained still accepts a new record.
  assign count_after_pop = count_reg - (PW + 1)'(pop);
  assign push_ok         = dump_hit && (count_after_pop != DEPTH_C);
  assign count_next      = count_after_pop + (PW + 1)'(push_ok);
  assign rd_ptr_next     = rd_ptr_reg + PW'(pop);

  // Head for the next cycle: when the queue drains to nothing on this edge
  // the incoming record bypasses the array; otherwise it is already stored.
  assign head_next = (count_after_pop == '0) ? push_rec : mem[rd_ptr_next];

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_rec;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      x_idx_reg      <= 5'd1;
      f_idx_reg      <= 5'd0;
      overflow_reg   <= 1'b0;
      dump_valid_reg <= 1'b0;
      dump_rec_reg   <= '0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      // Indices advance even when the record is dropped so the consumer can
      // see which registers are missing.
      if (dump_hit) begin
        if (hit_freg) begin
          f_idx_reg <= f_idx_reg + 5'd1;
        end else begin
          x_idx_reg <= x_idx_reg + 5'd1;
        end
        if (!push_ok) begin
          overflow_reg <= 1'b1;
        end
      end
      dump_valid_reg <= (count_next != '0);
      // Outputs hold their last value while the FIFO is empty.
      if (count_next != '0) begin
        dump_rec_reg <= head_next;
      end
    end
  end

  assign dump_valid_o = dump_valid_reg;
  assign dump_is_fp_o = dump_rec_reg[RW-1];
  assign dump_idx_o   = dump_rec_reg[RW-2 -: 5];
  assign dump_data_o  = dump_rec_reg[63:0];
  assign overflow_o   = overflow_reg;

endmodule

// File: tb/tb_mmio_sig_monitor.sv
// Randomised + directed bench for mmio_sig_monitor. A reference model tracks
// the run in terms of "edge at which done appears" and keeps the expected dump
// records in a queue; a monitor on the falling edge compares status every
// cycle and pops/compares records whenever one is handed over.

module tb_mmio_sig_monitor;

  localparam int SD    = 500;
  localparam int DEPTH = 8;
  localparam logic [30:0] A_STOP = 31'h60000000;
  localparam logic [30:0] A_TRAP = 31'h60000008;
  localparam logic [30:0] A_REG  = 31'h60000010;
  localparam logic [30:0] A_FREG = 31'h60000018;

  logic        clk, rst;
  logic        req, we;
  logic [30:0] addr;
  logic [63:0] wdata;
  logic [7:0]  strb;
  logic [31:0] simlen;
  logic        sot;
  logic        dump_valid, dump_ready, dump_is_fp, overflow, done;
  logic [4:0]  dump_idx;
  logic [63:0] dump_data;
  logic [15:0] trap_count;
  logic [1:0]  done_reason;

  mmio_sig_monitor #(
    .ADDR_STOP_SIG(A_STOP), .ADDR_TRAP_SIG(A_TRAP),
    .ADDR_REG_DUMP(A_REG), .ADDR_FREG_DUMP(A_FREG),
    .STOP_DELAY(SD), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .mmio_req_i(req), .mmio_we_i(we), .mmio_addr_i(addr),
    .mmio_wdata_i(wdata), .mmio_strb_i(strb),
    .simlen_i(simlen), .stop_on_trap_i(sot),
    .dump_valid_o(dump_valid), .dump_ready_i(dump_ready),
    .dump_is_fp_o(dump_is_fp), .dump_idx_o(dump_idx), .dump_data_o(dump_data),
    .overflow_o(overflow), .trap_count_o(trap_count),
    .done_o(done), .done_reason_o(done_reason)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic summary_and_finish();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
      if (fails > 40) summary_and_finish();
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: edges are numbered from 0 starting with the first
  // rising edge after reset release. A run ends at a known edge number.
  // ------------------------------------------------------------------
  int          m_edge;
  int          m_done_at;
  int          m_traps;
  logic [1:0]  m_reason;
  int          m_xi, m_fi;
  bit          m_ovf;
  logic [69:0] exp_q[$];
  bit          m_hw, m_fp;
  int          m_e, m_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edge = 0; m_done_at = -1; m_traps = 0; m_reason = 2'd0;
      m_xi = 1; m_fi = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      m_e  = m_edge;
      m_hw = req && we;
      if (m_done_at < 0) begin
        if (m_hw && addr == A_TRAP && m_traps < 65535) m_traps++;
        if (m_hw && addr == A_STOP) begin
          m_done_at = m_e + SD + 1; m_reason = 2'd1;
        end else if (m_hw && addr == A_TRAP && sot) begin
          m_done_at = m_e + SD + 1; m_reason = 2'd2;
        end else if (simlen != 0 && m_e == int'(simlen) - 1) begin
          m_done_at = m_e; m_reason = 2'd3;
        end
        if (m_hw && (addr == A_REG || addr == A_FREG)) begin
          m_fp  = (addr == A_FREG);
          m_idx = m_fp ? m_fi : m_xi;
          // The queue already reflects any record taken on this edge.
          if (exp_q.size() < DEPTH) exp_q.push_back({m_fp, 5'(m_idx), wdata});
          else m_ovf = 1;
          if (m_fp) m_fi = (m_fi + 1) % 32;
          else      m_xi = (m_xi + 1) % 32;
        end
      end
      m_edge++;
    end
  end

  // ------------------------------------------------------------------
  // Monitor: status every cycle, records on each handshake.
  // ------------------------------------------------------------------
  bit         exp_done;
  logic [20:0] exp_status, got_status;

  always @(negedge clk) begin
    exp_done   = (m_done_at >= 0) && (m_edge > m_done_at);
    exp_status = {exp_done, (exp_done ? m_reason : 2'd0), 16'(m_traps), m_ovf, (exp_q.size() != 0)};
    got_status = {done, done_reason, trap_count, overflow, dump_valid};
    check($sformatf("status@edge%0d(done,reason,traps,ovf,valid)", m_edge - 1), 128'(got_status), 128'(exp_status));
    if (exp_q.size() != 0 && dump_ready) begin
      check("record", 128'({dump_is_fp, dump_idx, dump_data}), 128'(exp_q[0]));
      exp_q.pop_front();
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after the rising edge.
  // ------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic idle_n(input int n);
    idle();
    repeat (n) tick();
  endtask

  task automatic wr(input logic [30:0] a, input logic [63:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int seen);
    seen = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done) begin
        seen = m_edge - 1;
        break;
      end
    end
  endtask

  int k, seen, op;

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; strb = 8'hFF; simlen = 32'd0; sot = 1'b0; dump_ready = 1'b1;
    idle();
    do_reset();

    // Dump records in order, each valid one cycle after its write.
    dump_ready = 1'b1;
    wr(A_REG, 64'h11);
    wr(A_REG, 64'h22);
    wr(A_FREG, 64'hAA);
    idle_n(4);
    check("t1_overflow", 128'(overflow), 128'(0));
    check("t1_x_next_idx", 128'(m_xi), 128'(3));

    // Randomised traffic: dumps of both kinds, reads, stray addresses,
    // counted traps, random back-pressure; indices wrap past 31.
    for (int i = 0; i < 400; i++) begin
      dump_ready = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 7);
      req = ($urandom_range(0, 7) != 0);
      we = 1'b1;
      wdata = {$urandom, $urandom};
      case (op)
        0, 1, 2: addr = A_REG;
        3, 4:    addr = A_FREG;
        5:       begin addr = A_REG; we = 1'b0; end
        6:       addr = 31'($urandom);
        default: addr = A_TRAP;
      endcase
      tick();
    end
    idle();
    dump_ready = 1'b1;
    idle_n(12);

    // Full FIFO with a simultaneous pop and push must not drop.
    do_reset();
    dump_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) wr(A_REG, 64'(100 + i));
    dump_ready = 1'b1;
    wr(A_REG, 64'h200);
    idle_n(12);
    check("full_pop_push_no_drop", 128'(overflow), 128'(0));

    // Overflow: 10 dumps into 8 slots, then index 11 after draining.
    do_reset();
    dump_ready = 1'b0;
    for (int i = 0; i < 10; i++) wr(A_REG, 64'(i + 1));
    idle_n(2);
    check("t5_overflow", 128'(overflow), 128'(1));
    dump_ready = 1'b1;
    idle_n(12);
    wr(A_REG, 64'hBEEF);
    idle_n(4);

    // Stop at edge 100; dumps during drain are ignored; done at edge 601.
    do_reset();
    idle_n(100);
    wr(A_STOP, 64'd1);
    idle_n(99);
    wr(A_REG, 64'h55);
    wr(A_FREG, 64'h66);
    wait_done(600, seen);
    check("t2_done_edge", 128'(seen), 128'(601));
    check("t2_reason", 128'(done_reason), 128'(1));

    // Traps counted only, then a trap that ends the run.
    do_reset();
    sot = 1'b0;
    repeat (3) begin wr(A_TRAP, 64'd0); idle_n(2); end
    idle_n(5);
    check("t3_trap_count3", 128'(trap_count), 128'(3));
    check("t3_not_done", 128'(done), 128'(0));
    sot = 1'b1;
    k = m_edge;
    wr(A_TRAP, 64'd0);
    wait_done(600, seen);
    check("t3_done_edge", 128'(seen), 128'(k + SD + 1));
    check("t3_reason", 128'(done_reason), 128'(2));
    wr(A_TRAP, 64'd0);
    idle_n(2);
    check("t3_trap_count_frozen", 128'(trap_count), 128'(4));
    sot = 1'b0;

    // Simlen limit.
    simlen = 32'd1000;
    do_reset();
    wait_done(1100, seen);
    check("t4_simlen_edge", 128'(seen), 128'(999));
    check("t4_reason", 128'(done_reason), 128'(3));
    simlen = 32'd1;
    do_reset();
    wait_done(10, seen);
    check("t4_simlen1_edge", 128'(seen), 128'(0));
    // Stop and simlen on the same edge: stop wins.
    simlen = 32'd51;
    do_reset();
    idle_n(50);
    wr(A_STOP, 64'd0);
    wait_done(600, seen);
    check("t4_stop_beats_simlen", 128'(seen), 128'(50 + SD + 1));
    check("t4_stop_beats_reason", 128'(done_reason), 128'(1));
    simlen = 32'd0;
    do_reset();
    idle_n(5000);
    check("t4_simlen0_not_done", 128'(done), 128'(0));

    // Asynchronous reset in the middle of a drain.
    do_reset();
    dump_ready = 1'b0;
    wr(A_TRAP, 64'd0);
    for (int i = 0; i < 3; i++) wr(A_REG, 64'(i));
    idle_n(10);
    wr(A_STOP, 64'd0);
    idle_n(250);
    rst = 1'b1;
    #1;
    check("t6_rst_done", 128'(done), 128'(0));
    check("t6_rst_valid", 128'(dump_valid), 128'(0));
    check("t6_rst_traps", 128'(trap_count), 128'(0));
    check("t6_rst_reason", 128'(done_reason), 128'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    dump_ready = 1'b1;
    idle_n(7);
    k = m_edge;
    wr(A_STOP, 64'd0);
    wait_done(600, seen);
    check("t6_done_edge", 128'(seen), 128'(k + SD + 1));

    idle_n(3);
    summary_and_finish();
  end

endmodule

// File: doc/mmio_sig_monitor.md
Name: mmio_sig_monitor

Overview:
- Synthesizable monitor on the tiny-SoC MMIO write port, directly downstream of top_tiny_soc.
- Decodes the signature addresses: stop, trap, integer register dump and FP register dump.
- Buffers register-dump records in a FIFO and runs the end-of-run state machine (stop/trap drain countdown, SIMLEN limit).
- Lets benches and FPGA harnesses consume run results through a valid/ready stream and status flags, without behavioural code.

Parameters:
ADDR_STOP_SIG, 31'h60000000, stop-request address
ADDR_TRAP_SIG, 31'h60000008, trap-signal address
ADDR_REG_DUMP, 31'h60000010, integer-register dump address
ADDR_FREG_DUMP, 31'h60000018, FP-register dump address
STOP_DELAY, 500, cycles drained after stop/trap before done
FIFO_DEPTH, 8, dump-record FIFO entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
mmio_req_i  in  1  MMIO request
mmio_we_i  in  1  MMIO write enable
mmio_addr_i  in  31  MMIO address
mmio_wdata_i  in  64  MMIO write data
mmio_strb_i  in  8  byte strobes (ignored; full 64-bit data captured)
simlen_i  in  32  cycle limit; 0 disables
stop_on_trap_i  in  1  1: trap starts drain; 0: trap only counted
dump_valid_o  out  1  dump record available
dump_ready_i  in  1  consumer accepts record
dump_is_fp_o  out  1  record kind: 0 = x-reg, 1 = f-reg
dump_idx_o  out  5  register index
dump_data_o  out  64  dumped value
overflow_o  out  1  sticky: a record was dropped
trap_count_o  out  16  traps seen, saturating
done_o  out  1  run finished (sticky)
done_reason_o  out  2  0 none, 1 stop, 2 trap, 3 simlen

Behaviour:
- Hit definition: a hit is mmio_req_i & mmio_we_i & (mmio_addr_i == ADDR_*) sampled at posedge. Reads are ignored.
- Reset values: all outputs 0. FSM = RUN. Cycle counter = 0. x-index = 1, f-index = 0. FIFO empty.
- Cycle counter: counts every posedge in RUN or DRAIN. Counting begins at the first edge after rst_i deasserts.
- FSM RUN:
  - Stop hit → DRAIN, reason=1, countdown loaded with STOP_DELAY.
  - Trap hit → trap_count_o increments (saturates at 16'hFFFF). If stop_on_trap_i, also → DRAIN, reason=2, countdown loaded.
  - Simlen: simlen_i != 0 and cycle counter == simlen_i-1 on this edge → DONE, reason=3.
  - If a stop/trap hit and the simlen condition occur on the same edge, stop/trap wins.
- FSM DRAIN:
  - Countdown decrements each edge. At countdown == 0 → DONE.
  - done_o is high from edge k+STOP_DELAY+1, where k is the hit edge.
  - Further stop/trap hits are ignored; trap_count_o does not change. The simlen check is disabled.
- FSM DONE: terminal until reset. done_o=1, done_reason_o held.
- Dump hits are honoured only in RUN; they are ignored in DRAIN and DONE.
  - Reg-dump hit pushes {0, x-index, wdata}, then x-index increments.
  - FP-dump hit pushes {1, f-index, wdata}, then f-index increments.
  - Both indices are 5-bit and wrap 31→0.
- FIFO:
  - First-word-fall-through; dump_* outputs are registered from the head entry.
  - Push is visible on dump_valid_o one cycle after the hit edge.
  - Pop occurs when dump_valid_o & dump_ready_i.
  - Full with simultaneous pop and push: both occur, no drop.
  - Full without pop: the record is dropped, overflow_o is set (sticky until reset), and the index still increments.
  - Empty: dump_valid_o=0; dump data outputs hold their last value.
- Reset mid-operation (async assert): immediately returns all state to the reset values. The FIFO contents are discarded.

Test Plan:
1. Dumps: with ready=1, write 0x11, 0x22 to 0x60000010, then 0xAA to 0x60000018 → records (0,1,0x11), (0,2,0x22), (1,0,0xAA), each valid one cycle after its write; overflow_o=0.
2. Stop drain: STOP_DELAY=500, stop hit at edge 100 → done_o first high at edge 601 with reason=1. Dump writes at edge 200 produce no record.
3. Trap: stop_on_trap_i=0, three trap hits → trap_count_o=3, done_o=0. Set stop_on_trap_i=1, then one trap hit → trap_count_o=4, reason=2 after STOP_DELAY+1 cycles.
4. Simlen: simlen_i=1000, no signature writes → done_o rises on edge 999 with reason=3. Simlen=0 at 5000 cycles → done_o=0.
5. Overflow: FIFO_DEPTH=8, ready=0, 10 reg dumps → 8 records held (indices 1-8), overflow_o=1. Drain, then one more dump → index 11.
6. Reset in DRAIN (countdown at 250): assert rst_i mid-cycle → done_o=0, FIFO empty, counters cleared immediately. After release, a new stop hit gives done exactly STOP_DELAY+1 edges later.
